hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 15 +
 rtl/hazard_match.sv | 48 ++++
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared pipeline types for the hazard scoreboard
package hazard_scoreboard_pkg;

  // Entries carry the widest supported register address; narrower RA_W is zero-extended.
  localparam int RA_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                valid;
    logic [RA_MAX_W-1:0] rd;
    logic                reg_wr;
    logic                is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-producer match, forward select and load-use for one source
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int RA_W       = 5,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [RA_W-1:0]                rs_i,
  input  logic                           rs_used_i,
  input  sb_entry_t [NUM_STAGES-1:0]     sb_i,
  output logic [SEL_W-1:0]               fwd_sel_o,
  output logic                           load_use_o
);

  logic [RA_MAX_W-1:0] rs_ext;
  int                  hit_idx;
  logic                hit_load;

  assign rs_ext = RA_MAX_W'(rs_i);

  // Walk oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    hit_idx  = 0;
    hit_load = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (sb_i[k-1].valid && sb_i[k-1].reg_wr && (sb_i[k-1].rd == rs_ext) &&
          (rs_i != '0) && rs_used_i) begin
        hit_idx  = k;
        hit_load = sb_i[k-1].is_load;
      end
    end
  end

  always_comb begin
    fwd_sel_o  = SEL_W'(FWD_RF);
    load_use_o = 1'b0;
    if (hit_idx != 0) begin
      if (hit_load && (hit_idx <= LOAD_LAT)) begin
        load_use_o = 1'b1;
      end else begin
        fwd_sel_o = SEL_W'(hit_idx);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pipeline hazard scoreboard: forwarding, load-use stall, flush
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int RA_W       = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_wr,
  input  logic             id_is_load,
  input  logic             br_taken,
  input  logic             ext_stall,
  output logic             stall_d,
  output logic             flush_d,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  sb_entry_t [NUM_STAGES-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]           flush_cnt_q, flush_cnt_d;

  logic [SEL_W-1:0] sel_a, sel_b;
  logic             lu_a, lu_b;
  logic             flush_raw, lu_stall, issue;
  sb_entry_t        id_entry;

  hazard_match #(
    .NUM_STAGES(NUM_STAGES), .RA_W(RA_W), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_match_a (
    .rs_i(id_rs1), .rs_used_i(id_rs1_used), .sb_i(sb_q),
    .fwd_sel_o(sel_a), .load_use_o(lu_a)
  );

  hazard_match #(
    .NUM_STAGES(NUM_STAGES), .RA_W(RA_W), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) u_match_b (
    .rs_i(id_rs2), .rs_used_i(id_rs2_used), .sb_i(sb_q),
    .fwd_sel_o(sel_b), .load_use_o(lu_b)
  );

  // A taken branch kills the decode slot, which also cancels any load-use stall on it.
  always_comb begin
    flush_raw = br_taken & ~ext_stall;
    lu_stall  = (lu_a | lu_b) & id_valid & ~flush_raw;
    issue     = id_valid & ~lu_stall & ~flush_raw & ~ext_stall;

    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = RA_MAX_W'(id_rd);
    id_entry.reg_wr  = id_reg_wr;
    id_entry.is_load = id_is_load;
  end

  always_comb begin
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    if (!rst) begin
      stall_d   = lu_stall | ext_stall;
      flush_d   = flush_raw;
      fwd_sel_a = sel_a;
      fwd_sel_b = sel_b;
    end
  end

  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_stall) begin
      sb_d[0] = issue ? id_entry : '0;
      for (int k = 1; k < NUM_STAGES; k++) begin
        sb_d[k] = sb_q[k-1];
      end
    end
    if (lu_stall && !ext_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_raw && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed bench against an in-flight instruction model
module tb_hazard_scoreboard;

  localparam int NS  = 3;
  localparam int RAW = 5;
  localparam int LL  = 1;
  localparam int CW  = 4;
  localparam int SW  = $clog2(NS + 1);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_valid;
  logic [RAW-1:0] id_rs1, id_rs2, id_rd;
  logic           id_rs1_used, id_rs2_used, id_reg_wr, id_is_load;
  logic           br_taken, ext_stall;
  logic           stall_d, flush_d;
  logic [SW-1:0]  fwd_sel_a, fwd_sel_b;
  logic [CW-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_STAGES(NS), .RA_W(RAW), .LOAD_LAT(LL), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .br_taken(br_taken), .ext_stall(ext_stall),
    .stall_d(stall_d), .flush_d(flush_d),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: list of issued instructions, each aging one stage per unfrozen cycle.
  typedef struct {
    int rd;
    bit wr;
    bit ld;
    int stage;
  } inst_t;

  inst_t pipe[$];
  int    m_stall_cnt, m_flush_cnt;
  bit    e_flush, e_stall, e_lu_stall, e_issue;
  int    e_sel_a, e_sel_b;

  function automatic void resolve(input int rs, input bit used, output int sel, output bit lu);
    int best;
    bit best_ld;
    best    = NS + 1;
    best_ld = 1'b0;
    sel     = 0;
    lu      = 1'b0;
    if (used && rs != 0) begin
      foreach (pipe[i]) begin
        if (pipe[i].wr && pipe[i].rd == rs && pipe[i].stage < best) begin
          best    = pipe[i].stage;
          best_ld = pipe[i].ld;
        end
      end
      if (best <= NS) begin
        if (best_ld && best <= LL) lu = 1'b1;
        else sel = best;
      end
    end
  endfunction

  task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int wr, input int ld, input int br, input int ext,
                       input int r);
    id_valid    = (v != 0);
    id_rs1      = RAW'(rs1);
    id_rs1_used = (u1 != 0);
    id_rs2      = RAW'(rs2);
    id_rs2_used = (u2 != 0);
    id_rd       = RAW'(rd);
    id_reg_wr   = (wr != 0);
    id_is_load  = (ld != 0);
    br_taken    = (br != 0);
    ext_stall   = (ext != 0);
    rst         = (r != 0);
  endtask

  task automatic evaluate;
    bit lua, lub;
    #1;
    resolve(int'(id_rs1), id_rs1_used, e_sel_a, lua);
    resolve(int'(id_rs2), id_rs2_used, e_sel_b, lub);
    e_flush    = br_taken && !ext_stall;
    e_lu_stall = (lua || lub) && id_valid && !e_flush;
    e_stall    = e_lu_stall || ext_stall;
    e_issue    = id_valid && !e_stall && !e_flush;
    if (rst) begin
      check_eq("stall_d", 32'(stall_d), 0);
      check_eq("flush_d", 32'(flush_d), 0);
      check_eq("fwd_sel_a", 32'(fwd_sel_a), 0);
      check_eq("fwd_sel_b", 32'(fwd_sel_b), 0);
    end else begin
      check_eq("stall_d", 32'(stall_d), 32'(e_stall));
      check_eq("flush_d", 32'(flush_d), 32'(e_flush));
      check_eq("fwd_sel_a", 32'(fwd_sel_a), e_sel_a);
      check_eq("fwd_sel_b", 32'(fwd_sel_b), e_sel_b);
    end
    check_eq("stall_cnt", 32'(stall_cnt), m_stall_cnt);
    check_eq("flush_cnt", 32'(flush_cnt), m_flush_cnt);
  endtask

  task automatic advance;
    inst_t t;
    @(posedge clk);
    if (rst) begin
      pipe.delete();
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (e_lu_stall && !ext_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (e_flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (!ext_stall) begin
        foreach (pipe[i]) pipe[i].stage++;
        while (pipe.size() > 0 && pipe[0].stage > NS) void'(pipe.pop_front());
        if (e_issue) begin
          t.rd    = int'(id_rd);
          t.wr    = id_reg_wr;
          t.ld    = id_is_load;
          t.stage = 1;
          pipe.push_back(t);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    evaluate;
    advance;
  endtask

  task automatic load_use_once;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    evaluate;
    advance;
    drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
    evaluate;
    advance;
    evaluate;
    advance;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    do_reset;

    // producer in stage 1 forwards to decode
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); evaluate; advance;
    drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0); evaluate;
    check_eq("r037_fwd_a", 32'(fwd_sel_a), 1);
    check_eq("r037_stall", 32'(stall_d), 0);
    advance;

    // load-use on rs2: one stall cycle then forward from stage 2
    do_reset;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); evaluate; advance;
    drive(1, 1, 1, 7, 1, 8, 1, 0, 0, 0, 0); evaluate;
    check_eq("r038_stall", 32'(stall_d), 1);
    check_eq("r038_fwd_b_rf", 32'(fwd_sel_b), 0);
    advance;
    evaluate;
    check_eq("r038_unstall", 32'(stall_d), 0);
    check_eq("r038_fwd_b", 32'(fwd_sel_b), 2);
    check_eq("r038_stall_cnt", 32'(stall_cnt), 1);
    advance;

    // youngest of two writers wins; x0 never forwards
    do_reset;
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); evaluate; advance;
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); evaluate; advance;
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0); evaluate; advance;
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0); evaluate;
    check_eq("r039_youngest", 32'(fwd_sel_a), 1);
    advance;
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); evaluate; advance;
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0); evaluate;
    check_eq("r039_x0_a", 32'(fwd_sel_a), 0);
    check_eq("r039_x0_b", 32'(fwd_sel_b), 0);
    advance;

    // branch beats pending load-use; flushed slot becomes a bubble
    do_reset;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); evaluate; advance;
    drive(1, 7, 1, 0, 0, 7, 1, 0, 1, 0, 0); evaluate;
    check_eq("r040_flush", 32'(flush_d), 1);
    check_eq("r040_stall", 32'(stall_d), 0);
    advance;
    drive(1, 7, 1, 0, 0, 3, 1, 0, 0, 0, 0); evaluate;
    check_eq("r040_bubble_fwd", 32'(fwd_sel_a), 2);
    check_eq("r040_flush_cnt", 32'(flush_cnt), 1);
    advance;

    // branch held across ext_stall is honoured on release
    do_reset;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); evaluate; advance;
    repeat (4) begin
      drive(1, 5, 1, 0, 0, 6, 1, 0, 1, 1, 0); evaluate;
      check_eq("r041_frozen_fwd", 32'(fwd_sel_a), 1);
      check_eq("r041_no_flush", 32'(flush_d), 0);
      check_eq("r041_stall", 32'(stall_d), 1);
      advance;
    end
    drive(1, 5, 1, 0, 0, 6, 1, 0, 1, 0, 0); evaluate;
    check_eq("r041_release_flush", 32'(flush_d), 1);
    advance;
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0); evaluate;
    check_eq("r041_after_fwd", 32'(fwd_sel_a), 2);
    advance;

    // counter saturation, then reset mid-hazard
    do_reset;
    repeat (CNT_MAX - 1) load_use_once;
    evaluate;
    check_eq("r042_cnt_near", 32'(stall_cnt), CNT_MAX - 1);
    advance;
    repeat (3) load_use_once;
    evaluate;
    check_eq("r042_cnt_sat", 32'(stall_cnt), CNT_MAX);
    advance;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); evaluate; advance;
    drive(1, 7, 1, 7, 1, 8, 1, 0, 1, 0, 1); evaluate;
    check_eq("r042_rst_stall", 32'(stall_d), 0);
    check_eq("r042_rst_flush", 32'(flush_d), 0);
    advance;
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0, 0, 0); evaluate;
    check_eq("r042_post_cnt", 32'(stall_cnt), 0);
    check_eq("r042_post_stall", 32'(stall_d), 0);
    check_eq("r042_post_fwd", 32'(fwd_sel_a), 0);
    advance;

    repeat (3000) begin
      drive($urandom_range(0, 3) != 0 ? 1 : 0,
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0 ? 1 : 0,
            $urandom_range(0, 7) == 0 ? 1 : 0,
            $urandom_range(0, 5) == 0 ? 1 : 0,
            $urandom_range(0, 63) == 0 ? 1 : 0);
      evaluate;
      advance;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
